// File: rtl/inert_sensor_serf.sv
// inert_sensor_serf: SPI responder model of the NEMO 6-axis inertial sensor.
// Mode-3 16-bit command frames, config registers and a periodic data-ready interrupt with coherent snapshots.
module inert_sensor_serf #(
    parameter logic [15:0] INT_PERIOD = 16'd50000,
    parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] roll_rt_in,
    input  logic [15:0] yaw_rt_in,
    input  logic [15:0] ax_in,
    input  logic [15:0] ay_in,
    output logic        setup_done,
    output logic        ovr
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SYNC_W  = 3;

    localparam logic [CNT_W-1:0] BITS_ADDR = CNT_W'(7);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(16);
    localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(17);

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL1     = 7'h10;
    localparam logic [6:0] ADDR_CTRL2     = 7'h11;
    localparam logic [6:0] ADDR_CTRL5     = 7'h14;
    localparam logic [6:0] ADDR_AY_H      = 7'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_W-1:0]    ss_sync_q, ss_sync_d;
    logic [SYNC_W-1:0]    sclk_sync_q, sclk_sync_d;
    logic [SYNC_W-1:0]    mosi_sync_q, mosi_sync_d;
    logic                 mosi_smpl_q, mosi_smpl_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]           int1_ctrl_q, int1_ctrl_d;
    logic [7:0]           ctrl1_q, ctrl1_d;
    logic [7:0]           ctrl2_q, ctrl2_d;
    logic [7:0]           ctrl5_q, ctrl5_d;
    logic [3:0]           seen_q, seen_d;
    logic                 setup_done_q, setup_done_d;
    logic [15:0]          per_cnt_q, per_cnt_d;
    logic                 evt_pend_q, evt_pend_d;
    logic                 int_q, int_d;
    logic                 ovr_q, ovr_d;
    logic [15:0]          snap_ptch_q, snap_ptch_d;
    logic [15:0]          snap_roll_q, snap_roll_d;
    logic [15:0]          snap_yaw_q, snap_yaw_d;
    logic [15:0]          snap_ax_q, snap_ax_d;
    logic [15:0]          snap_ay_q, snap_ay_d;

    logic                 ss_fall_c, ss_rise_c, sclk_fall_c, sclk_rise_c;
    logic [6:0]           rd_addr_c, wr_addr_c;
    logic [7:0]           wr_data_c, rd_byte_c;
    logic                 int_en_c, period_hit_c, evt_c, int_clr_c, int_off_c;

    assign ss_fall_c   = ~ss_sync_q[1] &  ss_sync_q[2];
    assign ss_rise_c   =  ss_sync_q[1] & ~ss_sync_q[2];
    assign sclk_fall_c = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign sclk_rise_c =  sclk_sync_q[1] & ~sclk_sync_q[2];

    // Address as it stands on the 8th fall; committed fields once all 16 bits are in.
    assign rd_addr_c = {shreg_q[5:0], mosi_smpl_q};
    assign wr_addr_c = shreg_q[14:8];
    assign wr_data_c = shreg_q[7:0];

    assign int_en_c     = int1_ctrl_q[1];
    assign period_hit_c = int_en_c && (per_cnt_q == (INT_PERIOD - 16'd1));
    assign evt_c        = period_hit_c | evt_pend_q;

    // Read data mux.
    always_comb begin
        rd_byte_c = 8'h00;
        case (rd_addr_c)
            ADDR_INT1_CTRL: rd_byte_c = int1_ctrl_q;
            ADDR_WHO_AM_I:  rd_byte_c = WHO_AM_I;
            ADDR_CTRL1:     rd_byte_c = ctrl1_q;
            ADDR_CTRL2:     rd_byte_c = ctrl2_q;
            ADDR_CTRL5:     rd_byte_c = ctrl5_q;
            7'h22:          rd_byte_c = snap_ptch_q[7:0];
            7'h23:          rd_byte_c = snap_ptch_q[15:8];
            7'h24:          rd_byte_c = snap_roll_q[7:0];
            7'h25:          rd_byte_c = snap_roll_q[15:8];
            7'h26:          rd_byte_c = snap_yaw_q[7:0];
            7'h27:          rd_byte_c = snap_yaw_q[15:8];
            7'h28:          rd_byte_c = snap_ax_q[7:0];
            7'h29:          rd_byte_c = snap_ax_q[15:8];
            7'h2A:          rd_byte_c = snap_ay_q[7:0];
            ADDR_AY_H:      rd_byte_c = snap_ay_q[15:8];
            default:        rd_byte_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ss_sync_d    = {ss_sync_q[1:0], SS_n};
        sclk_sync_d  = {sclk_sync_q[1:0], SCLK};
        mosi_sync_d  = {mosi_sync_q[1:0], MOSI};
        mosi_smpl_d  = mosi_smpl_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        int1_ctrl_d  = int1_ctrl_q;
        ctrl1_d      = ctrl1_q;
        ctrl2_d      = ctrl2_q;
        ctrl5_d      = ctrl5_q;
        seen_d       = seen_q;
        per_cnt_d    = per_cnt_q;
        evt_pend_d   = evt_pend_q;
        int_d        = int_q;
        ovr_d        = ovr_q;
        snap_ptch_d  = snap_ptch_q;
        snap_roll_d  = snap_roll_q;
        snap_yaw_d   = snap_yaw_q;
        snap_ax_d    = snap_ax_q;
        snap_ay_d    = snap_ay_q;
        int_clr_c    = 1'b0;
        int_off_c    = 1'b0;

        if (sclk_rise_c) begin
            mosi_smpl_d = mosi_sync_q[2];
        end

        case (state_q)
            IDLE: begin
                if (ss_fall_c) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sclk_fall_c) begin
                    // Read byte is spliced in above the command byte on the 8th fall.
                    if (bit_cnt_q == BITS_ADDR) begin
                        shreg_d = {rd_byte_c, shreg_q[6:0], mosi_smpl_q};
                    end else begin
                        shreg_d = {shreg_q[14:0], mosi_smpl_q};
                    end
                    if (bit_cnt_q != BITS_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                if (ss_rise_c) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (bit_cnt_q == BITS_FULL) begin
                    if (!shreg_q[15]) begin
                        case (wr_addr_c)
                            ADDR_INT1_CTRL: begin
                                int1_ctrl_d = wr_data_c;
                                seen_d[0]   = 1'b1;
                                int_off_c   = ~wr_data_c[1];
                            end
                            ADDR_CTRL1: begin
                                ctrl1_d   = wr_data_c;
                                seen_d[1] = 1'b1;
                            end
                            ADDR_CTRL2: begin
                                ctrl2_d   = wr_data_c;
                                seen_d[2] = 1'b1;
                            end
                            ADDR_CTRL5: begin
                                ctrl5_d   = wr_data_c;
                                seen_d[3] = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (wr_addr_c == ADDR_AY_H) begin
                        int_clr_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (int_en_c) begin
            per_cnt_d = period_hit_c ? '0 : per_cnt_q + 16'd1;
        end

        // Data-ready events wait for IDLE so the snapshot is stable for a whole frame.
        evt_pend_d = evt_c;
        if (evt_c && (state_q == IDLE)) begin
            evt_pend_d = 1'b0;
            if (int_q) begin
                ovr_d = 1'b1;
            end else begin
                int_d       = 1'b1;
                snap_ptch_d = ptch_rt_in;
                snap_roll_d = roll_rt_in;
                snap_yaw_d  = yaw_rt_in;
                snap_ax_d   = ax_in;
                snap_ay_d   = ay_in;
            end
        end

        if (int_clr_c) begin
            int_d = 1'b0;
        end
        if (int_off_c) begin
            per_cnt_d  = '0;
            evt_pend_d = 1'b0;
            int_d      = 1'b0;
        end
    end

    assign setup_done_d = &seen_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ss_sync_q    <= '0;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            mosi_smpl_q  <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            int1_ctrl_q  <= '0;
            ctrl1_q      <= '0;
            ctrl2_q      <= '0;
            ctrl5_q      <= '0;
            seen_q       <= '0;
            setup_done_q <= 1'b0;
            per_cnt_q    <= '0;
            evt_pend_q   <= 1'b0;
            int_q        <= 1'b0;
            ovr_q        <= 1'b0;
            snap_ptch_q  <= '0;
            snap_roll_q  <= '0;
            snap_yaw_q   <= '0;
            snap_ax_q    <= '0;
            snap_ay_q    <= '0;
        end else begin
            state_q      <= state_d;
            ss_sync_q    <= ss_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            mosi_smpl_q  <= mosi_smpl_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            int1_ctrl_q  <= int1_ctrl_d;
            ctrl1_q      <= ctrl1_d;
            ctrl2_q      <= ctrl2_d;
            ctrl5_q      <= ctrl5_d;
            seen_q       <= seen_d;
            setup_done_q <= setup_done_d;
            per_cnt_q    <= per_cnt_d;
            evt_pend_q   <= evt_pend_d;
            int_q        <= int_d;
            ovr_q        <= ovr_d;
            snap_ptch_q  <= snap_ptch_d;
            snap_roll_q  <= snap_roll_d;
            snap_yaw_q   <= snap_yaw_d;
            snap_ax_q    <= snap_ax_d;
            snap_ay_q    <= snap_ay_d;
        end
    end

    assign MISO       = shreg_q[15];
    assign INT        = int_q;
    assign setup_done = setup_done_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Directed bench for inert_sensor_serf: a bit-banged SPI monarch plus hand-computed expectations.
module tb_inert_sensor_serf;

    localparam int P    = 4000;
    localparam int HALF = 5;

    logic        clk, rst, SS_n, SCLK, MOSI, MISO, INT, setup_done, ovr;
    logic [15:0] ptch_rt_in, roll_rt_in, yaw_rt_in, ax_in, ay_in;

    int unsigned cyc;
    int          total, bad;

    inert_sensor_serf #(.INT_PERIOD(16'd4000), .WHO_AM_I(8'h6A)) dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .INT        (INT),
        .ptch_rt_in (ptch_rt_in),
        .roll_rt_in (roll_rt_in),
        .yaw_rt_in  (yaw_rt_in),
        .ax_in      (ax_in),
        .ay_in      (ay_in),
        .setup_done (setup_done),
        .ovr        (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SCLK is dropped before SS_n so each counted fall follows the rise that sampled its bit.
    task automatic frame_open();
        SCLK = 1'b0;
        tick(HALF);
        SS_n = 1'b0;
        tick(HALF);
    endtask

    task automatic clock_bits(input logic [15:0] cmd, input int first, input int n,
                              inout logic [7:0] rd);
        for (int i = first; i < first + n; i++) begin
            MOSI = cmd[15-i];
            tick(HALF);
            if (i >= 8) rd = {rd[6:0], MISO};
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic frame_close(output int unsigned t_rise);
        tick(HALF);
        SS_n   = 1'b1;
        t_rise = cyc;
        tick(HALF);
        SCLK = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input logic [15:0] cmd, input int nfalls, output logic [7:0] rd);
        int unsigned t;
        rd = 8'h00;
        frame_open();
        clock_bits(cmd, 0, nfalls, rd);
        frame_close(t);
    endtask

    logic [7:0]  rd;
    logic [7:0]  exp_snap [10];
    int unsigned t_en, t_dummy;
    int          n;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        ptch_rt_in = 16'h1234;
        roll_rt_in = 16'h5678;
        yaw_rt_in  = 16'h9ABC;
        ax_in      = 16'h0102;
        ay_in      = 16'hA5C3;
        exp_snap[0] = 8'h34; exp_snap[1] = 8'h12;
        exp_snap[2] = 8'h78; exp_snap[3] = 8'h56;
        exp_snap[4] = 8'hBC; exp_snap[5] = 8'h9A;
        exp_snap[6] = 8'h02; exp_snap[7] = 8'h01;
        exp_snap[8] = 8'hC3; exp_snap[9] = 8'hA5;
        tick(4);
        rst = 1'b0;

        // Idle with interrupts disabled.
        tick(2 * P);
        check("idle_int", 32'(INT), 32'd0);
        check("idle_miso", 32'(MISO), 32'd0);
        check("idle_ovr", 32'(ovr), 32'd0);
        check("idle_setup", 32'(setup_done), 32'd0);

        // Config writes; INT1_CTRL enables the period counter.
        rd = 8'h00;
        frame_open();
        clock_bits(16'h0D02, 0, 16, rd);
        frame_close(t_en);
        xfer(16'h1062, 16, rd);
        xfer(16'h1162, 16, rd);
        check("setup_after3", 32'(setup_done), 32'd0);
        xfer(16'h1460, 16, rd);
        check("setup_after4", 32'(setup_done), 32'd1);
        xfer(16'h9000, 16, rd);
        check("rd_ctrl1", 32'(rd), 32'h62);
        xfer(16'h8F00, 16, rd);
        check("rd_whoami", 32'(rd), 32'h6A);
        xfer(16'hB500, 16, rd);
        check("rd_unmapped", 32'(rd), 32'h00);
        check("int_early", 32'(INT), 32'd0);

        // First data-ready: 4 clocks of sync/commit then a full period.
        n = 0;
        while (INT !== 1'b1 && n < 2 * P) begin
            tick(1);
            n++;
        end
        check("int_rise", 32'(INT), 32'd1);
        total++;
        assert ((cyc - t_en) >= P + 2 && (cyc - t_en) <= P + 6) else begin
            bad++;
            $error("FAIL int_latency: observed=%0d expected=%0d..%0d", cyc - t_en, P + 2, P + 6);
        end

        // Inputs move; the snapshot must not.
        ptch_rt_in = 16'hFFFF;
        roll_rt_in = 16'h0000;
        yaw_rt_in  = 16'h1111;
        ax_in      = 16'h2222;
        ay_in      = 16'h3333;
        xfer(16'hA200, 16, rd);
        check("snap_ptch_l", 32'(rd), 32'h34);
        xfer(16'hA300, 16, rd);
        check("snap_ptch_h", 32'(rd), 32'h12);

        for (int a = 0; a < 9; a++) begin
            xfer(16'(16'hA200 + (a << 8)), 16, rd);
            check($sformatf("snap_%0h", 8'h22 + a), 32'(rd), 32'(exp_snap[a]));
            check($sformatf("int_hold_%0h", 8'h22 + a), 32'(INT), 32'd1);
        end

        // ay high byte read clears INT on SS_n rise.
        rd = 8'h00;
        frame_open();
        clock_bits(16'hAB00, 0, 16, rd);
        tick(HALF);
        check("int_before_ab_rise", 32'(INT), 32'd1);
        SS_n = 1'b0;
        SS_n = 1'b1;
        n = 0;
        while (INT !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        check("int_cleared", 32'(INT), 32'd0);
        total++;
        assert (n <= 5) else begin
            bad++;
            $error("FAIL int_clr_latency: observed=%0d expected<=5", n);
        end
        tick(HALF);
        SCLK = 1'b1;
        tick(8);
        check("snap_2b", 32'(rd), 32'hA5);
        check("ovr_before", 32'(ovr), 32'd0);

        // Unserviced: next period snapshots, the one after sets ovr.
        n = 0;
        while (INT !== 1'b1 && n < 2 * P) begin
            tick(1);
            n++;
        end
        check("int_rerise", 32'(INT), 32'd1);
        check("ovr_not_yet", 32'(ovr), 32'd0);
        xfer(16'hA200, 16, rd);
        check("snap2_ptch_l", 32'(rd), 32'hFF);
        xfer(16'hA700, 16, rd);
        check("snap2_yaw_h", 32'(rd), 32'h11);
        n = 0;
        while (ovr !== 1'b1 && n < 2 * P) begin
            tick(1);
            n++;
        end
        check("ovr_set", 32'(ovr), 32'd1);
        check("int_still", 32'(INT), 32'd1);

        // Aborted write frame after 9 falls is discarded.
        xfer(16'h1000, 9, rd);
        xfer(16'h9000, 16, rd);
        check("abort_ctrl1", 32'(rd), 32'h62);

        // Reset in the middle of a frame; remainder of that frame is ignored.
        rd = 8'h00;
        frame_open();
        clock_bits(16'h1055, 0, 5, rd);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_int", 32'(INT), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_setup", 32'(setup_done), 32'd0);
        check("rst_miso", 32'(MISO), 32'd0);
        clock_bits(16'h1055, 5, 11, rd);
        frame_close(t_dummy);
        xfer(16'h9000, 16, rd);
        check("post_rst_ctrl1", 32'(rd), 32'h00);
        xfer(16'h8F00, 16, rd);
        check("post_rst_who", 32'(rd), 32'h6A);
        xfer(16'h1055, 16, rd);
        xfer(16'h9000, 16, rd);
        check("post_rst_write", 32'(rd), 32'h55);
        check("post_rst_int", 32'(INT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
